// File: rtl/writeback_commit_unit.sv
// Writeback commit unit: queues ALU/load results, drives the register file write port and keeps a per-register pending scoreboard.
// Optional forwarding from in-flight results is enabled by defining WB_FORWARD_EN.
module writeback_commit_unit #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int CNTW  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            dbg_valid,
    input  logic [4:0]      dbg_addr,
    input  logic [XLEN-1:0] dbg_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            rs1_hazard,
    output logic            rs2_hazard,
    output logic            fwd1_valid,
    output logic            fwd2_valid,
    output logic [XLEN-1:0] fwd1_data,
    output logic [XLEN-1:0] fwd2_data,
    output logic            writeEnable,
    output logic [4:0]      writeAddr,
    output logic [XLEN-1:0] writeData
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic [4:0]      r_rd   [DEPTH];
    logic [XLEN-1:0] r_data [DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [AW:0]     r_count;
    logic [CNTW-1:0] r_cnt  [32];

    logic            w_full, w_empty, w_push, w_pop, w_inc_en, w_dec_en;
    logic [4:0]      w_push_rd, w_head_rd;
    logic [XLEN-1:0] w_push_data, w_head_data;
    logic [4:0]      w_rs    [2];
    logic            w_hz    [2];
    logic            w_fv    [2];
    logic [XLEN-1:0] w_fd    [2];

    assign w_full      = (r_count == (AW+1)'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign mem_ready   = !w_full && !reset;
    assign alu_ready   = !w_full && !mem_valid && !reset;
    assign w_push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    assign w_push_rd   = mem_valid ? mem_rd   : alu_rd;
    assign w_push_data = mem_valid ? mem_data : alu_result;
    assign w_head_rd   = r_rd[r_rptr];
    assign w_head_data = r_data[r_rptr];
    // Debug owns the write port; the queue stalls while it is active.
    assign w_pop       = !dbg_valid && !w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_rd[r_wptr]   <= w_push_rd;
                r_data[r_wptr] <= w_push_data;
                r_wptr         <= r_wptr + AW'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + (AW+1)'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            writeEnable <= 1'b0;
            writeAddr   <= '0;
            writeData   <= '0;
        end else if (dbg_valid) begin
            writeEnable <= (dbg_addr != 5'd0);
            writeAddr   <= dbg_addr;
            writeData   <= dbg_data;
        end else if (w_pop) begin
            writeEnable <= (w_head_rd != 5'd0);
            writeAddr   <= w_head_rd;
            writeData   <= w_head_data;
        end else begin
            writeEnable <= 1'b0;
        end
    end

    assign issue_ready = !reset && ((r_cnt[issue_rd] != CNT_MAX) || (issue_rd == 5'd0));
    assign w_inc_en    = issue_valid && issue_ready && (issue_rd != 5'd0);
    assign w_dec_en    = w_pop && (w_head_rd != 5'd0);

    // Simultaneous increment and decrement of one register cancel out.
    always_ff @(posedge clk) begin
        for (int r = 0; r < 32; r++) begin
            if (reset || r == 0) begin
                r_cnt[r] <= '0;
            end else begin
                logic inc, dec;
                inc = w_inc_en && (issue_rd == 5'(r));
                dec = w_dec_en && (w_head_rd == 5'(r)) && (r_cnt[r] != '0);
                if (inc && !dec)
                    r_cnt[r] <= r_cnt[r] + CNTW'(1);
                else if (dec && !inc)
                    r_cnt[r] <= r_cnt[r] - CNTW'(1);
            end
        end
    end

    assign w_rs[0] = rs1_addr;
    assign w_rs[1] = rs2_addr;

`ifdef WB_FORWARD_EN
    // Walk oldest to youngest so the last match is the youngest value.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            logic [AW:0]   nm;
            logic [AW-1:0] idx;
            w_fv[s] = 1'b0;
            w_fd[s] = '0;
            nm      = '0;
            if (w_rs[s] != 5'd0 && writeEnable && writeAddr == w_rs[s]) begin
                w_fv[s] = 1'b1;
                w_fd[s] = writeData;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = r_rptr + AW'(i);
                if (w_rs[s] != 5'd0 && (AW+1)'(i) < r_count && r_rd[idx] == w_rs[s]) begin
                    w_fv[s] = 1'b1;
                    w_fd[s] = r_data[idx];
                    nm      = nm + (AW+1)'(1);
                end
            end
            w_hz[s] = (w_rs[s] != 5'd0) && (r_cnt[w_rs[s]] != '0) &&
                      !(w_fv[s] && (8'(r_cnt[w_rs[s]]) == 8'(nm)));
        end
    end
`else
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_fv[s] = 1'b0;
            w_fd[s] = '0;
            w_hz[s] = (w_rs[s] != 5'd0) && (r_cnt[w_rs[s]] != '0);
        end
    end
`endif

    assign rs1_hazard = w_hz[0];
    assign rs2_hazard = w_hz[1];
    assign fwd1_valid = w_fv[0];
    assign fwd2_valid = w_fv[1];
    assign fwd1_data  = w_fd[0];
    assign fwd2_data  = w_fd[1];
endmodule

// File: doc/writeback_commit_unit.md
Name: writeback_commit_unit

Overview:
- Initiator side of the register file write port: collects results from the ALU path and the load path, queues them, and drives writeEnable/writeAddr/writeData into register_file one write per cycle.
- Keeps a per-register pending scoreboard fed by the issue stage, so decode can detect RAW hazards against rs1/rs2.
- A debug write path shares the single write port and has top priority.

Parameters:
- DEPTH, 4, commit FIFO entries (power of two, 2..16)
- XLEN, 32, data width
- CNTW, 2, width of the per-register pending counter (saturates at 2^CNTW-1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid
- alu_rd  in  5  ALU destination
- alu_result  in  XLEN  ALU data
- mem_valid  in  1  load result valid
- mem_ready  out  1  load result accepted when high with mem_valid
- mem_rd  in  5  load destination
- mem_data  in  XLEN  load data
- dbg_valid  in  1  debug write request (always taken)
- dbg_addr  in  5  debug destination
- dbg_data  in  XLEN  debug data
- issue_valid  in  1  instruction with destination issued
- issue_rd  in  5  issued destination
- issue_ready  out  1  pending counter of issue_rd not saturated
- rs1_addr, rs2_addr  in  5 each  decode source registers
- rs1_hazard, rs2_hazard  out  1 each  source has an outstanding write
- fwd1_valid, fwd2_valid  out  1 each  forwarding hit (optional feature)
- fwd1_data, fwd2_data  out  XLEN each  forwarded value (optional feature)
- writeEnable  out  1  to register_file
- writeAddr  out  5  to register_file
- writeData  out  XLEN  to register_file

Behaviour:
- Reset (synchronous, active-high): FIFO emptied, all pending counters 0, writeEnable/writeAddr/writeData = 0. In-flight entries are discarded, not written. Ready outputs are 0 during reset.
- Ready logic:
  - mem_ready = !full && !reset.
  - alu_ready = !full && !mem_valid && !reset. Load wins a tie.
  - At most one push per cycle. No push into a full FIFO, even when a pop occurs in the same cycle.
- Commit stage (registered outputs), evaluated at each edge:
  - If dbg_valid: load debug write into the outputs. writeEnable = (dbg_addr != 0). FIFO does not pop.
  - Else if FIFO non-empty: pop head. writeEnable = (head.rd != 0), with addr/data from the head.
  - Else: writeEnable = 0; addr/data hold their previous values.
- Latency: an entry pushed at edge N into an empty FIFO (no debug) drives writeEnable after edge N+1. The register file captures it at edge N+2.
- Push and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
- rd = 0 results are accepted and consumed but never assert writeEnable.
- Scoreboard:
  - Per-register counter cnt[r].
  - Increment when issue_valid && issue_ready && issue_rd != 0.
  - Decrement when a FIFO pop commits rd = r (r != 0). Debug writes do not decrement.
  - Increment and decrement of the same r in one cycle leave cnt[r] unchanged.
  - issue_ready = (cnt[issue_rd] != max) || (issue_rd == 0).
  - rsN_hazard = (rsN_addr != 0) && (cnt[rsN_addr] != 0), combinational.
- The sources guarantee every pushed result had a matching issue. A decrement of a zero counter is ignored.

Optional Feature:
- Macro: WB_FORWARD_EN.
- Defined:
  - fwdN_valid = 1 when rsN_addr != 0 and it matches a valid FIFO entry or the current output register with writeEnable = 1.
  - fwdN_data is taken from the youngest match; FIFO entries are younger than the output register.
  - rsN_hazard is suppressed (0) when fwdN_valid = 1 and cnt[rsN_addr] equals the number of matching in-flight entries.
- Not defined: fwdN_valid and fwdN_data are tied to 0; hazards behave as described in Behaviour.

Test Plan:
- Issue x4, then alu_valid rd=4 data 0x0000FFFF → writeEnable=1, writeAddr=4, writeData=0x0000FFFF two edges after acceptance; rs1_addr=4 shows hazard=1 until the commit edge, then 0.
- alu_valid and mem_valid in the same cycle (rd 8 data 0xFFFF0000, rd 9 data 0x12345678) → alu_ready=0; x9 commits first, x8 on the next cycle.
- Hold dbg_valid high for 6 cycles while pushing 5 ALU results (DEPTH=4) → mem_ready and alu_ready drop after 4 pushes; no FIFO writes reach the outputs during debug; after dbg_valid drops, the 4 entries commit in order.
- Issue x0 and push alu rd=0 data 0xDEADBEEF → writeEnable stays 0; cnt unchanged; rs1_addr=0 shows hazard=0.
- Issue x5 three times (CNTW=2) → issue_ready=0 on the fourth attempt; after one x5 commit, issue_ready=1. Issue and commit of x5 in the same cycle → count unchanged.
- Fill 3 entries, assert reset for 1 cycle → no writeEnable afterwards; all hazards 0; outputs 0.
